// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, opcodes and the ID->EX stage record for the decode stage
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int NREG    = 16;
  localparam int INSTR_W = 32;

  typedef logic [DATA_W-1:0] t_data;
  typedef logic [3:0]        t_reg_addr;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_PASS
  } t_alu_op;

  typedef enum logic {takeGPR = 1'b0, takeImm = 1'b1} t_src;

  // ALU-class opcodes carry their t_alu_op in bits [2:0]
  localparam logic [4:0] OPC_ADD  = 5'h00;
  localparam logic [4:0] OPC_SUB  = 5'h01;
  localparam logic [4:0] OPC_AND  = 5'h02;
  localparam logic [4:0] OPC_OR   = 5'h03;
  localparam logic [4:0] OPC_XOR  = 5'h04;
  localparam logic [4:0] OPC_SHL  = 5'h05;
  localparam logic [4:0] OPC_SHR  = 5'h06;
  localparam logic [4:0] OPC_ADDI = 5'h08;
  localparam logic [4:0] OPC_ANDI = 5'h0A;
  localparam logic [4:0] OPC_ORI  = 5'h0B;
  localparam logic [4:0] OPC_XORI = 5'h0C;
  localparam logic [4:0] OPC_SHLI = 5'h0D;
  localparam logic [4:0] OPC_SHRI = 5'h0E;
  localparam logic [4:0] OPC_NOP  = 5'h10;
  localparam logic [4:0] OPC_LDI  = 5'h11;
  localparam logic [4:0] OPC_OUT  = 5'h12;

  typedef struct packed {
    t_src      ALUsrc1x1;
    t_src      ALUsrc2x1;
    t_data     dat1x1;
    t_data     dat2x1;
    t_data     immx1;
    t_alu_op   ALUopx1;
    logic      wr_enx1;
    logic      dataoutvx1;
    t_reg_addr dstx1;
  } t_IDtoEX;

  localparam t_IDtoEX IDEX_BUBBLE = '{
    ALUsrc1x1: takeGPR, ALUsrc2x1: takeGPR, dat1x1: '0, dat2x1: '0, immx1: '0,
    ALUopx1: OP_PASS, wr_enx1: 1'b0, dataoutvx1: 1'b0, dstx1: '0
  };

  function automatic t_data sext_imm(input logic [14:0] imm);
    return {{(DATA_W-15){imm[14]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode_reg_file.sv
// rtl/instr_decode_reg_file.sv - GPR array, 2 async read ports, 1 write port, r0 hard-wired to zero
module reg_file #(
  parameter int NREG = 16,
  parameter int DW   = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2
);

  logic [DW-1:0] gpr [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      gpr[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : gpr[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : gpr[rd_addr2];

endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - decode stage: field decode, operand bypass, EX interlock, ID->EX register
// Optional EX->ID forwarding path enabled by defining ID_EX_FWD_EN.
module instr_decode
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               internal_reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               ex_stall,
  input  logic               ex_wr_en,
  input  logic [3:0]         ex_dst,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               wb_wr_en,
  input  logic [3:0]         wb_dst,
  input  logic [DATA_W-1:0]  wb_data,
  output t_IDtoEX            reg_IDtoEX,
  output logic               illegal_op,
  output logic [15:0]        stall_cnt
);

  logic [4:0] opc;
  t_reg_addr  dst, src1, src2;
  t_data      rd1, rd2, opnd1, opnd2;
  t_IDtoEX    dec;
  logic       use1, use2, dec_illegal;
  logic       hazard, accept;

  assign opc  = instr[31:27];
  assign dst  = instr[26:23];
  assign src1 = instr[22:19];
  assign src2 = instr[18:15];

  reg_file #(.NREG(NREG), .DW(DATA_W)) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wb_wr_en),
    .wr_addr  (wb_dst),
    .wr_data  (wb_data),
    .rd_addr1 (src1),
    .rd_addr2 (src2),
    .rd_data1 (rd1),
    .rd_data2 (rd2)
  );

  // Later assignments win: EX result beats WB write-through beats the array
  always_comb begin
    opnd1 = rd1;
    opnd2 = rd2;
    if (src1 != '0 && wb_wr_en && wb_dst == src1) opnd1 = wb_data;
    if (src2 != '0 && wb_wr_en && wb_dst == src2) opnd2 = wb_data;
`ifdef ID_EX_FWD_EN
    if (src1 != '0 && ex_wr_en && ex_dst == src1) opnd1 = ex_result;
    if (src2 != '0 && ex_wr_en && ex_dst == src2) opnd2 = ex_result;
`endif
  end

  always_comb begin
    dec             = IDEX_BUBBLE;
    dec.dat1x1      = opnd1;
    dec.dat2x1      = opnd2;
    dec.immx1       = sext_imm(instr[14:0]);
    dec.dstx1       = dst;
    use1            = 1'b0;
    use2            = 1'b0;
    dec_illegal     = 1'b0;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR: begin
        dec.ALUopx1 = t_alu_op'(opc[2:0]);
        dec.wr_enx1 = 1'b1;
        use1        = 1'b1;
        use2        = 1'b1;
      end
      OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SHLI, OPC_SHRI: begin
        dec.ALUopx1   = t_alu_op'(opc[2:0]);
        dec.ALUsrc2x1 = takeImm;
        dec.wr_enx1   = 1'b1;
        use1          = 1'b1;
      end
      OPC_LDI: begin
        dec.ALUsrc1x1 = takeImm;
        dec.wr_enx1   = 1'b1;
      end
      OPC_OUT: begin
        dec.dataoutvx1 = 1'b1;
        use1           = 1'b1;
      end
      OPC_NOP: ;
      default: dec_illegal = 1'b1;
    endcase
    if (dst == '0) dec.wr_enx1 = 1'b0;
  end

`ifdef ID_EX_FWD_EN
  logic unused_hz;
  assign unused_hz = use1 ^ use2;
  assign hazard    = 1'b0;
`else
  logic unused_ex;
  assign unused_ex = ^ex_result;
  assign hazard    = instr_valid && ex_wr_en && ex_dst != '0 &&
                     ((use1 && ex_dst == src1) || (use2 && ex_dst == src2));
`endif

  assign instr_ready = !ex_stall && !hazard;
  assign accept      = instr_valid && instr_ready && !internal_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_IDtoEX <= IDEX_BUBBLE;
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      if (internal_reset)  reg_IDtoEX <= IDEX_BUBBLE;
      else if (!ex_stall)  reg_IDtoEX <= accept ? dec : IDEX_BUBBLE;
      if (accept && dec_illegal) illegal_op <= 1'b1;
      if (instr_valid && hazard && !ex_stall && !internal_reset && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - directed table, corner sequences and randomized pipeline-model check of instr_decode
module tb_instr_decode;
  import pipe_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, internal_reset = 1'b0, instr_valid = 1'b0;
  logic        ex_stall = 1'b0, ex_wr_en = 1'b0, wb_wr_en = 1'b0;
  logic [31:0] instr = '0;
  logic [3:0]  ex_dst = '0, wb_dst = '0;
  logic [15:0] ex_result = '0, wb_data = '0;
  logic        instr_ready, illegal_op;
  logic [15:0] stall_cnt;
  t_IDtoEX     reg_IDtoEX;
  int          total = 0, bad = 0;

  instr_decode dut (
    .clk(clk), .rst_n(rst_n), .internal_reset(internal_reset), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .ex_stall(ex_stall),
    .ex_wr_en(ex_wr_en), .ex_dst(ex_dst), .ex_result(ex_result), .wb_wr_en(wb_wr_en),
    .wb_dst(wb_dst), .wb_data(wb_data), .reg_IDtoEX(reg_IDtoEX), .illegal_op(illegal_op),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        wbw;
    logic [3:0]  wbd;
    logic [15:0] wbv;
    logic        wr, ov, s1i, s2i;
    logic [15:0] imm;
    logic [3:0]  dst;
    logic [15:0] d1;
    logic        full;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [4:0]  opc;
    logic [3:0]  dst;
    logic        wr, ov, s1i, s2i, u1, u2;
    logic [2:0]  op;
    logic [15:0] imm, d1, d2, res;
  } xrec_t;

  vec_t        tbl [9];
  xrec_t       exo, nxt, bub;
  logic [15:0] arch [16];
  logic        wbw_m;
  logic [3:0]  wbd_m;
  logic [15:0] wbv_m;
  int          exp_stall;
  logic        exp_ill;
  logic [4:0]  legal_ops [16];
  logic [4:0]  r_opc;
  logic [3:0]  r_s1, r_s2, r_dst;
  logic        r_legal, r_wr, r_ov, r_s1i, r_s2i, r_u1, r_u2, r_hz, r_rdy, r_acc;
  logic [2:0]  r_op;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    instr_valid = 0; internal_reset = 0; ex_stall = 0; ex_wr_en = 0; wb_wr_en = 0;
    ex_dst = 0; wb_dst = 0; ex_result = 0; wb_data = 0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] o, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [14:0] im);
    return {o, d, s1, s2, im};
  endfunction

  // Architectural meaning of each opcode
  function automatic void ref_dec(input logic [4:0] o, output logic legal, output logic wr,
                                  output logic ov, output logic s1i, output logic s2i,
                                  output logic u1, output logic u2, output logic [2:0] op);
    legal = 1; wr = 0; ov = 0; s1i = 0; s2i = 0; u1 = 0; u2 = 0; op = 3'(OP_PASS);
    case (o)
      OPC_ADD:  begin op = 3'(OP_ADD); wr = 1; u1 = 1; u2 = 1; end
      OPC_SUB:  begin op = 3'(OP_SUB); wr = 1; u1 = 1; u2 = 1; end
      OPC_AND:  begin op = 3'(OP_AND); wr = 1; u1 = 1; u2 = 1; end
      OPC_OR:   begin op = 3'(OP_OR);  wr = 1; u1 = 1; u2 = 1; end
      OPC_XOR:  begin op = 3'(OP_XOR); wr = 1; u1 = 1; u2 = 1; end
      OPC_SHL:  begin op = 3'(OP_SHL); wr = 1; u1 = 1; u2 = 1; end
      OPC_SHR:  begin op = 3'(OP_SHR); wr = 1; u1 = 1; u2 = 1; end
      OPC_ADDI: begin op = 3'(OP_ADD); wr = 1; u1 = 1; s2i = 1; end
      OPC_ANDI: begin op = 3'(OP_AND); wr = 1; u1 = 1; s2i = 1; end
      OPC_ORI:  begin op = 3'(OP_OR);  wr = 1; u1 = 1; s2i = 1; end
      OPC_XORI: begin op = 3'(OP_XOR); wr = 1; u1 = 1; s2i = 1; end
      OPC_SHLI: begin op = 3'(OP_SHL); wr = 1; u1 = 1; s2i = 1; end
      OPC_SHRI: begin op = 3'(OP_SHR); wr = 1; u1 = 1; s2i = 1; end
      OPC_LDI:  begin wr = 1; s1i = 1; end
      OPC_OUT:  begin ov = 1; u1 = 1; end
      OPC_NOP:  ;
      default:  legal = 0;
    endcase
  endfunction

  function automatic logic [15:0] ref_exec(input logic [4:0] o, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] im);
    case (o)
      OPC_ADD:  return a + b;
      OPC_SUB:  return a - b;
      OPC_AND:  return a & b;
      OPC_OR:   return a | b;
      OPC_XOR:  return a ^ b;
      OPC_SHL:  return a << b[3:0];
      OPC_SHR:  return a >> b[3:0];
      OPC_ADDI: return a + im;
      OPC_ANDI: return a & im;
      OPC_ORI:  return a | im;
      OPC_XORI: return a ^ im;
      OPC_SHLI: return a << im[3:0];
      OPC_SHRI: return a >> im[3:0];
      OPC_LDI:  return im;
      default:  return a;
    endcase
  endfunction

  // Newest program-order value of a register: in-flight EX, then WB, then committed state
  function automatic logic [15:0] latest(input logic [3:0] s);
    if (s == 0) return 16'd0;
    if (exo.wr && exo.dst == s) return exo.res;
    if (wbw_m && wbd_m == s) return wbv_m;
    return arch[s];
  endfunction

  initial begin
    tbl[0] = '{mk(OPC_ADDI, 4'd1, 4'd0, 4'd0, 15'd5), 1'b0, 4'd0, 16'h0,
               1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 4'd1, 16'h0, 1'b1};
    tbl[1] = '{mk(OPC_OUT, 4'd0, 4'd4, 4'd0, 15'd0), 1'b1, 4'd4, 16'hBEEF,
               1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 16'hBEEF, 1'b1};
    tbl[2] = '{mk(OPC_OUT, 4'd0, 4'd4, 4'd0, 15'd0), 1'b0, 4'd0, 16'h0,
               1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 16'hBEEF, 1'b1};
    tbl[3] = '{mk(OPC_LDI, 4'd2, 4'd0, 4'd0, 15'h7FFF), 1'b0, 4'd0, 16'h0,
               1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 4'd2, 16'h0, 1'b1};
    tbl[4] = '{mk(OPC_ADD, 4'd0, 4'd4, 4'd4, 15'd0), 1'b0, 4'd0, 16'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 16'hBEEF, 1'b1};
    tbl[5] = '{mk(OPC_NOP, 4'd3, 4'd1, 4'd2, 15'h4000), 1'b0, 4'd0, 16'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 16'h0, 1'b0};
    tbl[6] = '{mk(5'h1F, 4'd7, 4'd0, 4'd0, 15'd0), 1'b0, 4'd0, 16'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 16'h0, 1'b0};
    tbl[7] = '{mk(OPC_OUT, 4'd0, 4'd0, 4'd0, 15'd0), 1'b1, 4'd0, 16'h1234,
               1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 16'h0, 1'b1};
    tbl[8] = '{mk(OPC_SUB, 4'd9, 4'd4, 4'd4, 15'h4001), 1'b0, 4'd0, 16'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 16'hC001, 4'd9, 16'hBEEF, 1'b1};
    legal_ops = '{OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL, OPC_SHR, OPC_ADDI,
                  OPC_ANDI, OPC_ORI, OPC_XORI, OPC_SHLI, OPC_SHRI, OPC_NOP, OPC_LDI, OPC_OUT};
    bub = '{default: '0};

    // Reset state
    idle();
    tick(); tick();
    chk("rst_wr", 32'(reg_IDtoEX.wr_enx1), 32'd0);
    chk("rst_ov", 32'(reg_IDtoEX.dataoutvx1), 32'd0);
    chk("rst_op", 32'(reg_IDtoEX.ALUopx1), 32'(OP_PASS));
    chk("rst_sel", 32'({reg_IDtoEX.ALUsrc1x1, reg_IDtoEX.ALUsrc2x1}), 32'd0);
    chk("rst_dat", 32'({reg_IDtoEX.dat1x1, reg_IDtoEX.dstx1}), 32'd0);
    chk("rst_ill", 32'(illegal_op), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    rst_n = 1;

    // Single-instruction decode table
    for (int i = 0; i < 9; i++) begin
      instr = tbl[i].ins; instr_valid = 1;
      wb_wr_en = tbl[i].wbw; wb_dst = tbl[i].wbd; wb_data = tbl[i].wbv;
      #1;
      chk($sformatf("t%0d_ready", i), 32'(instr_ready), 32'd1);
      tick(); idle();
      chk($sformatf("t%0d_wr", i), 32'(reg_IDtoEX.wr_enx1), 32'(tbl[i].wr));
      chk($sformatf("t%0d_ov", i), 32'(reg_IDtoEX.dataoutvx1), 32'(tbl[i].ov));
      if (tbl[i].full) begin
        chk($sformatf("t%0d_s1", i), 32'(reg_IDtoEX.ALUsrc1x1), 32'(tbl[i].s1i));
        chk($sformatf("t%0d_s2", i), 32'(reg_IDtoEX.ALUsrc2x1), 32'(tbl[i].s2i));
        chk($sformatf("t%0d_imm", i), 32'(reg_IDtoEX.immx1), 32'(tbl[i].imm));
        chk($sformatf("t%0d_dst", i), 32'(reg_IDtoEX.dstx1), 32'(tbl[i].dst));
        chk($sformatf("t%0d_d1", i), 32'(reg_IDtoEX.dat1x1), 32'(tbl[i].d1));
      end
    end
    chk("ill_sticky", 32'(illegal_op), 32'd1);

    // EX stall holds the output and blocks acceptance
    instr = mk(OPC_ADDI, 4'd1, 4'd0, 4'd0, 15'd5); instr_valid = 1;
    tick();
    ex_stall = 1; instr = mk(OPC_ORI, 4'd5, 4'd1, 4'd0, 15'd3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready", k), 32'(instr_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_hold", k),
          32'({reg_IDtoEX.wr_enx1, reg_IDtoEX.dstx1, reg_IDtoEX.immx1}), 32'({1'b1, 4'd1, 16'd5}));
    end
    ex_stall = 0;
    #1;
    chk("release_ready", 32'(instr_ready), 32'd1);
    tick(); idle();
    chk("release_out", 32'({reg_IDtoEX.dstx1, reg_IDtoEX.immx1, 1'(reg_IDtoEX.ALUsrc2x1)}),
        32'({4'd5, 16'd3, 1'b1}));

    // Back-to-back dependency LDI r2,7 ; ADD r3,r2,r2
    instr = mk(OPC_LDI, 4'd2, 4'd0, 4'd0, 15'd7); instr_valid = 1;
    tick();
    instr = mk(OPC_ADD, 4'd3, 4'd2, 4'd2, 15'd0);
    ex_wr_en = 1; ex_dst = 4'd2; ex_result = 16'd7;
    #1;
`ifdef ID_EX_FWD_EN
    chk("dep_ready", 32'(instr_ready), 32'd1);
    tick(); idle();
    chk("dep_dat", 32'({reg_IDtoEX.dat1x1, reg_IDtoEX.dat2x1}), 32'({16'd7, 16'd7}));
    chk("dep_stall", 32'(stall_cnt), 32'd0);
`else
    chk("dep_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("dep_bubble", 32'(reg_IDtoEX.wr_enx1), 32'd0);
    chk("dep_stall", 32'(stall_cnt), 32'd1);
    ex_wr_en = 0; wb_wr_en = 1; wb_dst = 4'd2; wb_data = 16'd7;
    #1;
    chk("dep_ready2", 32'(instr_ready), 32'd1);
    tick(); idle();
    chk("dep_dat", 32'({reg_IDtoEX.dat1x1, reg_IDtoEX.dat2x1}), 32'({16'd7, 16'd7}));
`endif
    chk("dep_dst", 32'({reg_IDtoEX.wr_enx1, reg_IDtoEX.dstx1}), 32'({1'b1, 4'd3}));

    // internal_reset beats ex_stall; r0 writes dropped
    internal_reset = 1; ex_stall = 1; instr_valid = 1; instr = mk(OPC_ADDI, 4'd6, 4'd0, 4'd0, 15'd9);
    wb_wr_en = 1; wb_dst = 4'd0; wb_data = 16'h5555;
    tick(); idle();
    chk("flush_out", 32'({reg_IDtoEX.wr_enx1, reg_IDtoEX.dataoutvx1}), 32'd0);
    instr = mk(OPC_OUT, 4'd0, 4'd0, 4'd0, 15'd0); instr_valid = 1;
    tick(); idle();
    chk("r0_zero", 32'({reg_IDtoEX.dataoutvx1, reg_IDtoEX.dat1x1}), 32'({1'b1, 16'd0}));

    // Asynchronous reset mid-stream
    #2 rst_n = 0;
    #1;
    chk("arst_out", 32'({reg_IDtoEX.wr_enx1, reg_IDtoEX.dataoutvx1}), 32'd0);
    chk("arst_ill", 32'(illegal_op), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    tick(); rst_n = 1;
    instr = mk(OPC_OUT, 4'd0, 4'd4, 4'd0, 15'd0); instr_valid = 1;
    tick(); idle();
    chk("arst_gpr", 32'(reg_IDtoEX.dat1x1), 32'd0);

    // Randomized traffic against the pipeline model
    rst_n = 0; tick(); rst_n = 1;
    exo = bub; wbw_m = 0; wbd_m = 0; wbv_m = 0; exp_stall = 0; exp_ill = 0;
    for (int i = 0; i < 16; i++) arch[i] = 16'd0;
    for (int n = 0; n < 4000; n++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      r_opc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : legal_ops[$urandom_range(0, 15)];
      r_dst = 4'($urandom_range(0, 7));
      r_s1  = 4'($urandom_range(0, 7));
      r_s2  = 4'($urandom_range(0, 7));
      instr = mk(r_opc, r_dst, r_s1, r_s2, 15'($urandom));
      ex_stall = ($urandom_range(0, 4) == 0);
      internal_reset = ($urandom_range(0, 19) == 0);
      ex_wr_en = exo.wr; ex_dst = exo.dst; ex_result = exo.res;
      wb_wr_en = wbw_m; wb_dst = wbd_m; wb_data = wbv_m;

      ref_dec(r_opc, r_legal, r_wr, r_ov, r_s1i, r_s2i, r_u1, r_u2, r_op);
      if (r_dst == 0) r_wr = 0;
`ifdef ID_EX_FWD_EN
      r_hz = 0;
`else
      r_hz = instr_valid && exo.wr && exo.dst != 0 &&
             ((r_u1 && exo.dst == r_s1) || (r_u2 && exo.dst == r_s2));
`endif
      r_rdy = !ex_stall && !r_hz;
      r_acc = instr_valid && r_rdy && !internal_reset;
      nxt = '{vld: r_legal && r_opc != OPC_NOP, opc: r_opc, dst: r_dst, wr: r_wr, ov: r_ov,
              s1i: r_s1i, s2i: r_s2i, u1: r_u1, u2: r_u2, op: r_op,
              imm: {instr[14], instr[14:0]}, d1: latest(r_s1), d2: latest(r_s2), res: 16'd0};
      nxt.res = ref_exec(r_opc, nxt.d1, nxt.d2, nxt.imm);
      #1;
      chk("rnd_ready", 32'(instr_ready), 32'(r_rdy));
      tick();

      if (wbw_m && wbd_m != 0) arch[wbd_m] = wbv_m;
      if (!ex_stall && exo.wr) begin
        wbw_m = 1; wbd_m = exo.dst; wbv_m = exo.res;
      end else begin
        wbw_m = 0;
      end
      if (internal_reset) exo = bub;
      else if (!ex_stall) exo = r_acc ? nxt : bub;
      if (r_hz && !ex_stall && !internal_reset && exp_stall != 65535) exp_stall++;
      if (r_acc && !r_legal) exp_ill = 1;

      chk("rnd_wr", 32'(reg_IDtoEX.wr_enx1), 32'(exo.wr));
      chk("rnd_ov", 32'(reg_IDtoEX.dataoutvx1), 32'(exo.ov));
      chk("rnd_stall", 32'(stall_cnt), 32'(exp_stall));
      chk("rnd_ill", 32'(illegal_op), 32'(exp_ill));
      if (exo.vld) begin
        chk("rnd_dst", 32'(reg_IDtoEX.dstx1), 32'(exo.dst));
        chk("rnd_op", 32'(reg_IDtoEX.ALUopx1), 32'(exo.op));
        chk("rnd_sel", 32'({reg_IDtoEX.ALUsrc1x1, reg_IDtoEX.ALUsrc2x1}), 32'({exo.s1i, exo.s2i}));
        chk("rnd_imm", 32'(reg_IDtoEX.immx1), 32'(exo.imm));
        if (exo.u1) chk("rnd_d1", 32'(reg_IDtoEX.dat1x1), 32'(exo.d1));
        if (exo.u2) chk("rnd_d2", 32'(reg_IDtoEX.dat2x1), 32'(exo.d2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
